// File: rtl/itch_axis_pkg.sv
// Shared types and lane geometry for the two-feed ITCH AXI-Stream arbiter.
package itch_axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_WAIT,
    EMIT
  } arb_state_t;

  // Feed index: 0 = line A, 1 = line B.
  typedef logic src_t;

  localparam int LANES      = 4;
  localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/itch_axis_word_serializer.sv
// Holds one AXIS beat and hands out its strobed bytes, lowest lane first,
// skipping cleared lanes without bubbles.
module itch_axis_word_serializer
  import itch_axis_pkg::*;
#(
  parameter int NUM_LANES = LANES,
  parameter int IDX_W     = LANE_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NUM_LANES*8-1:0] load_data,
  input  logic [NUM_LANES-1:0]   load_strb,
  input  logic                   load_last,
  output logic                   empty,
  output logic [7:0]             data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   last,
  output logic                   final_lane
);

  logic [NUM_LANES*8-1:0] data_q;
  logic [NUM_LANES-1:0]   mask_q;
  logic [NUM_LANES-1:0]   rest;
  logic                   last_q;
  logic [IDX_W-1:0]       lane;

  // NOTE: default assigned before the loop so no path leaves lane unassigned (no latch).
  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) lane = IDX_W'(i);
    end
  end

  assign rest       = mask_q & ~(NUM_LANES'(1) << lane);
  assign valid      = |mask_q;
  assign empty      = ~valid;
  assign data       = data_q[{lane, 3'b000} +: 8];
  assign final_lane = valid && (rest == '0);
  assign last       = final_lane && last_q;

  // NOTE: the data register is reset as well so parser_byte reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
      data_q <= load_data;
      mask_q <= load_strb;
      last_q <= load_last;
    end else if (valid && ready) begin
      mask_q <= rest;
    end
  end

endmodule

// File: rtl/itch_axis_feed_arbiter.sv
// Round-robin, frame-granular arbiter feeding two AXIS market-data lines into
// the byte-wide ITCH parser, with a mid-frame stall timeout that aborts the frame.
module itch_axis_feed_arbiter
  import itch_axis_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = LANES * 8,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tstrb,
  input  logic                              s0_axis_tlast,
  input  logic                              s0_axis_tvalid,
  output logic                              s0_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tstrb,
  input  logic                              s1_axis_tlast,
  input  logic                              s1_axis_tvalid,
  output logic                              s1_axis_tready,
  output logic [7:0]                        parser_byte,
  output logic                              parser_valid,
  input  logic                              parser_ready,
  output logic                              parser_last,
  output logic                              parser_src,
  output logic                              parser_abort
);

  localparam int NUM_LANES = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int IDX_W     = lane_idx_width(NUM_LANES);
  localparam int TMR_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t state_q, state_d;
  src_t       grant_q, grant_d, last_grant_q;
  logic [TMR_W-1:0] tmr_q;

  logic                            sel_valid, sel_last, beat_empty;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] sel_data;
  logic [NUM_LANES-1:0]            sel_strb;
  logic                            timeout_hit, take;
  logic                            ser_load, ser_empty, ser_valid, ser_last, ser_final;
  logic [7:0]                      ser_data;

  assign sel_valid  = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_data   = grant_q ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_strb   = grant_q ? s1_axis_tstrb  : s0_axis_tstrb;
  assign sel_last   = grant_q ? s1_axis_tlast  : s0_axis_tlast;
  assign beat_empty = (sel_strb == '0);

  // Timeout wins over a beat arriving in the same cycle: tready is withheld then.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == GRANT_WAIT)
                       && (tmr_q == TMR_W'(TIMEOUT_CYCLES));
  assign take        = (state_q == GRANT_WAIT) && !timeout_hit && sel_valid;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d = GRANT_WAIT;
          if (s0_axis_tvalid && s1_axis_tvalid) grant_d = ~last_grant_q;
          else                                  grant_d = src_t'(s1_axis_tvalid);
        end
      end
      GRANT_WAIT: begin
        if (timeout_hit) state_d = IDLE;
        else if (take) begin
          if (!beat_empty)  state_d = EMIT;
          else if (sel_last) state_d = IDLE;
        end
      end
      EMIT: begin
        if (ser_valid && parser_ready && ser_final) state_d = ser_last ? IDLE : GRANT_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    ser_load       = 1'b0;
    if (state_q == GRANT_WAIT && !timeout_hit) begin
      s0_axis_tready = (grant_q == 1'b0);
      s1_axis_tready = (grant_q == 1'b1);
      ser_load       = sel_valid && !beat_empty && ser_empty;
    end
    parser_abort = timeout_hit || (take && beat_empty && sel_last);
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      grant_q <= grant_d;
      if (state_q == IDLE && state_d == GRANT_WAIT) last_grant_q <= grant_d;
    end
  end

  // Counts idle cycles of the granted feed while waiting for the next beat.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)                    tmr_q <= '0;
    else if (state_q != GRANT_WAIT || take) tmr_q <= '0;
    else if (!sel_valid)                    tmr_q <= tmr_q + TMR_W'(1);
  end

  itch_axis_word_serializer #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_serializer (
    .clk        (S_AXIS_ACLK),
    .rst_n      (S_AXIS_ARESETN),
    .load       (ser_load),
    .load_data  (sel_data),
    .load_strb  (sel_strb),
    .load_last  (sel_last),
    .empty      (ser_empty),
    .data       (ser_data),
    .valid      (ser_valid),
    .ready      (parser_ready),
    .last       (ser_last),
    .final_lane (ser_final)
  );

  assign parser_byte  = ser_data;
  assign parser_valid = ser_valid;
  assign parser_last  = ser_last;
  assign parser_src   = grant_q;

endmodule

// File: tb/tb_itch_axis_feed_arbiter.sv
// Scoreboard bench for itch_axis_feed_arbiter: feed drivers, a parser-side
// monitor popping expected bytes, and one task per scenario.
module tb_itch_axis_feed_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic [3:0]  s0_axis_tstrb = '0, s1_axis_tstrb = '0;
  logic        s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
  logic        s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic        s0_axis_tready, s1_axis_tready;
  logic [7:0]  parser_byte;
  logic        parser_valid, parser_last, parser_src, parser_abort;
  logic        parser_ready = 1'b1;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];

  int   checks = 0, fails = 0;
  int   cycle = 0, hs_count = 0, abort_count = 0, stall_count = 0, s1_ready_cycles = 0;
  int   last_hs_cycle = 0, abort_cycle = 0, abort_prev_hs = 0;
  logic ready_toggle = 1'b0;
  logic hs0 = 1'b0, hs1 = 1'b0;
  logic prev_stall = 1'b0;
  exp_t prev_out, exp_e, got;

  itch_axis_feed_arbiter #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .TIMEOUT_CYCLES       (TMO)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tstrb  (s0_axis_tstrb),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tstrb  (s1_axis_tstrb),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .parser_byte    (parser_byte),
    .parser_valid   (parser_valid),
    .parser_ready   (parser_ready),
    .parser_last    (parser_last),
    .parser_src     (parser_src),
    .parser_abort   (parser_abort)
  );

  always #5 clk = ~clk;

  // Feed drivers: present the queue head, pop it after a handshake.
  always begin
    @(negedge clk);
    hs0 = rst_n && s0_axis_tvalid && s0_axis_tready;
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) q0.delete(0);
    if (q0.size() > 0) begin
      s0_axis_tvalid = 1'b1;
      s0_axis_tdata  = q0[0].data;
      s0_axis_tstrb  = q0[0].strb;
      s0_axis_tlast  = q0[0].last;
    end else begin
      s0_axis_tvalid = 1'b0;
      s0_axis_tdata  = '0;
      s0_axis_tstrb  = '0;
      s0_axis_tlast  = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    hs1 = rst_n && s1_axis_tvalid && s1_axis_tready;
    @(posedge clk);
    #1;
    if (hs1 && q1.size() > 0) q1.delete(0);
    if (q1.size() > 0) begin
      s1_axis_tvalid = 1'b1;
      s1_axis_tdata  = q1[0].data;
      s1_axis_tstrb  = q1[0].strb;
      s1_axis_tlast  = q1[0].last;
    end else begin
      s1_axis_tvalid = 1'b0;
      s1_axis_tdata  = '0;
      s1_axis_tstrb  = '0;
      s1_axis_tlast  = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    parser_ready = ready_toggle ? ~parser_ready : 1'b1;
  end

  // Parser-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (s1_axis_tready) s1_ready_cycles++;
      got = '{b: parser_byte, last: parser_last, src: parser_src};
      if (prev_stall) begin
        checks++;
        if (!parser_valid || got !== prev_out) begin
          fails++;
          $display("FAIL stall_hold: got valid=%0b byte=%02h last=%0b src=%0b, required valid=1 byte=%02h last=%0b src=%0b",
                   parser_valid, got.b, got.last, got.src, prev_out.b, prev_out.last, prev_out.src);
        end
      end
      if (parser_abort) begin
        abort_count++;
        abort_cycle   = cycle;
        abort_prev_hs = last_hs_cycle;
        checks++;
        if (parser_valid !== 1'b0) begin
          fails++;
          $display("FAIL abort_with_valid: got parser_valid=%0b, required 0", parser_valid);
        end
      end
      if (parser_valid && parser_ready) begin
        hs_count++;
        last_hs_cycle = cycle;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got byte=%02h src=%0b, required no byte", got.b, got.src);
        end else begin
          exp_e = exp_q.pop_front();
          if (got !== exp_e) begin
            fails++;
            $display("FAIL byte_out: got byte=%02h last=%0b src=%0b, required byte=%02h last=%0b src=%0b",
                     got.b, got.last, got.src, exp_e.b, exp_e.last, exp_e.src);
          end
        end
      end
      if (parser_valid && !parser_ready) stall_count++;
      prev_stall = parser_valid && !parser_ready;
      prev_out   = got;
    end
  end

  task automatic send_beat(input logic feed, input logic [31:0] d, input logic [3:0] s, input logic l);
    beat_t bt;
    exp_t  e;
    int    hi;
    bt = '{data: d, strb: s, last: l};
    hi = -1;
    for (int i = 0; i < 4; i++) if (s[i]) hi = i;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        e.b    = d[8*i +: 8];
        e.last = l && (i == hi);
        e.src  = feed;
        exp_q.push_back(e);
      end
    end
    if (feed) q1.push_back(bt);
    else      q0.push_back(bt);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d bytes / %0d+%0d beats outstanding after %0d cycles, required 0",
               name, exp_q.size(), q0.size(), q1.size(), budget);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({parser_valid, parser_last, parser_abort, parser_src} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got valid/last/abort/src=%b, required 0000",
               {parser_valid, parser_last, parser_abort, parser_src});
    end
    checks++;
    if (parser_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_byte: got %02h, required 00", parser_byte);
    end
    checks++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_tready: got %b, required 00", {s0_axis_tready, s1_axis_tready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_feed();
    int r0;
    r0 = s1_ready_cycles;
    send_beat(1'b0, 32'h44332211, 4'hF, 1'b0);
    send_beat(1'b0, 32'h00006655, 4'h3, 1'b1);
    wait_drain("single_feed", 100);
    checks++;
    if (s1_ready_cycles - r0 !== 0) begin
      fails++;
      $display("FAIL single_feed_s1_tready: got %0d cycles high, required 0", s1_ready_cycles - r0);
    end
  endtask

  // Two-beat frames on both feeds from reset: A first, then strict alternation.
  task automatic test_round_robin();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      send_beat(1'b0, {16'h0, 8'hA0 + 8'(k), 8'hA8 + 8'(k)}, 4'h3, 1'b0);
      send_beat(1'b0, {24'h0, 8'hAF}, 4'h1, 1'b1);
      send_beat(1'b1, {16'h0, 8'hB0 + 8'(k), 8'hB8 + 8'(k)}, 4'h3, 1'b0);
      send_beat(1'b1, {24'h0, 8'hBF}, 4'h1, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("round_robin", 300);
  endtask

  task automatic test_strobe_stall();
    int st0;
    st0 = stall_count;
    ready_toggle = 1'b1;
    send_beat(1'b0, 32'hDDCCBBAA, 4'b1010, 1'b1);
    wait_drain("strobe_stall", 100);
    ready_toggle = 1'b0;
    checks++;
    if (stall_count - st0 <= 0) begin
      fails++;
      $display("FAIL strobe_stall_seen: got %0d stall cycles, required >0", stall_count - st0);
    end
  endtask

  task automatic test_timeout();
    int a0, n;
    a0 = abort_count;
    send_beat(1'b0, 32'h87654321, 4'hF, 1'b0);
    n = 0;
    while (!s0_axis_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s0_axis_tready) begin
      fails++;
      $display("FAIL timeout_grant: got s0_axis_tready=0 after %0d cycles, required 1", n);
    end
    send_beat(1'b1, 32'h0000C2C1, 4'h3, 1'b1);
    wait_drain("timeout", 200);
    checks++;
    if (abort_count - a0 !== 1) begin
      fails++;
      $display("FAIL timeout_abort_count: got %0d, required 1", abort_count - a0);
    end
    checks++;
    if (abort_cycle - abort_prev_hs !== TMO + 1) begin
      fails++;
      $display("FAIL timeout_abort_delay: got %0d cycles after last byte, required %0d",
               abort_cycle - abort_prev_hs, TMO + 1);
    end
  endtask

  task automatic test_zero_strobe();
    int a0;
    a0 = abort_count;
    send_beat(1'b1, 32'h11223344, 4'hF, 1'b0);
    send_beat(1'b1, 32'hDEADBEEF, 4'h0, 1'b1);
    wait_drain("zero_strobe", 100);
    checks++;
    if (abort_count - a0 !== 1) begin
      fails++;
      $display("FAIL zero_strobe_abort: got %0d pulses, required 1", abort_count - a0);
    end
    send_beat(1'b0, 32'h00000077, 4'h1, 1'b1);
    wait_drain("after_zero_strobe", 50);
  endtask

  task automatic test_reset_mid_frame();
    int h0, n;
    send_beat(1'b0, 32'h04030201, 4'hF, 1'b1);
    h0 = hs_count;
    n  = 0;
    while (hs_count - h0 < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (hs_count - h0 < 2) begin
      fails++;
      $display("FAIL midreset_progress: got %0d bytes, required 2", hs_count - h0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({parser_valid, parser_last, parser_abort, parser_src, parser_byte} !== 12'h000) begin
      fails++;
      $display("FAIL midreset_outputs: got valid/last/abort/src=%b byte=%02h, required 0000 00",
               {parser_valid, parser_last, parser_abort, parser_src}, parser_byte);
    end
    checks++;
    if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_tready: got %b, required 00", {s0_axis_tready, s1_axis_tready});
    end
    exp_q.delete();
    q0.delete();
    q1.delete();
    send_beat(1'b0, 32'h04030201, 4'hF, 1'b1);
    send_beat(1'b1, 32'h0000E2E1, 4'h3, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("midreset_replay", 100);
  endtask

  initial begin
    test_reset();
    test_single_feed();
    test_round_robin();
    test_strobe_stall();
    test_timeout();
    test_zero_strobe();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
